// File: rtl/mem_access_unit.sv
// MEM pipeline stage: valid/ready data-bus access with lane alignment, CP0 interrupt/exception redirect, WB output register.
// Optional build macro MEM_MISALIGN_CHK_EN raises EXC_ADEL/EXC_ADES on misaligned loads/stores instead of issuing them.
module mem_access_unit #(
    parameter int unsigned      DATA_W     = 32,
    parameter int unsigned      ADDR_W     = 32,
    parameter int unsigned      EXC_W      = 5,
    parameter logic [31:0]      EXC_VECTOR = 32'hbfc0_0380,
    parameter logic [EXC_W-1:0] EXC_INT    = EXC_W'(5'h10),
    parameter logic [EXC_W-1:0] EXC_ERET   = EXC_W'(5'h0e),
    parameter logic [EXC_W-1:0] EXC_ADEL   = EXC_W'(5'h04),
    parameter logic [EXC_W-1:0] EXC_ADES   = EXC_W'(5'h05)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_pc,
    input  logic [ADDR_W-1:0]   in_addr,
    input  logic [DATA_W-1:0]   in_wdata,
    input  logic [1:0]          in_size,
    input  logic                in_load,
    input  logic                in_store,
    input  logic                in_signed,
    input  logic                in_rf_we,
    input  logic [4:0]          in_rf_waddr,
    input  logic [DATA_W-1:0]   in_result,
    input  logic [EXC_W-1:0]    in_exc,
    input  logic [31:0]         cp0_status,
    input  logic [31:0]         cp0_cause,
    input  logic [31:0]         cp0_epc,
    output logic                dreq_valid,
    input  logic                dreq_ready,
    output logic                dreq_we,
    output logic [ADDR_W-1:0]   dreq_addr,
    output logic [DATA_W/8-1:0] dreq_wstrb,
    output logic [DATA_W-1:0]   dreq_wdata,
    input  logic                drsp_valid,
    input  logic [DATA_W-1:0]   drsp_rdata,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         out_pc,
    output logic                out_rf_we,
    output logic [4:0]          out_rf_waddr,
    output logic [DATA_W-1:0]   out_rf_wdata,
    output logic [EXC_W-1:0]    out_exc,
    output logic                flush,
    output logic [31:0]         new_pc,
    output logic                stall_req
);
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned LANE_W = $clog2(STRB_W);

    // state  | meaning
    // S_IDLE | accepting from EX, output register free or draining
    // S_REQ  | bus request presented, waiting for dreq_ready
    // S_WAIT | request taken, waiting for drsp_valid (data or store ack)
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              ready_en_q;
    logic              dreq_valid_q, dreq_we_q;
    logic [ADDR_W-1:0] dreq_addr_q;
    logic [STRB_W-1:0] dreq_wstrb_q;
    logic [DATA_W-1:0] dreq_wdata_q;
    logic [31:0]       p_pc_q;
    logic              p_rf_we_q, p_load_q, p_signed_q;
    logic [4:0]        p_waddr_q;
    logic [LANE_W-1:0] p_lane_q;
    logic [1:0]        p_size_q;
    logic [DATA_W-1:0] p_result_q;
    logic              out_valid_q, out_rf_we_q, flush_q;
    logic [31:0]       out_pc_q, new_pc_q;
    logic [4:0]        out_rf_waddr_q;
    logic [DATA_W-1:0] out_rf_wdata_q;
    logic [EXC_W-1:0]  out_exc_q;

    logic [1:0]        size_eff;
    logic [LANE_W-1:0] lane_raw, lane_mask, lane_eff;
    logic [STRB_W-1:0] size_strb;
    logic [7:0]        ip, im;
    logic              int_pend, accept, access;
    logic [EXC_W-1:0]  exc_fin;
    logic [DATA_W-1:0] rsh, keep, ld_data;
    logic              sbit;

    assign size_eff = (DATA_W == 32 && in_size == 2'd3) ? 2'd2 : in_size;
    assign lane_raw = in_addr[LANE_W-1:0];

    always_comb begin
        size_strb = '0;
        lane_mask = '1;
        case (size_eff)
            2'd0:    begin size_strb = STRB_W'(8'h01); lane_mask = '1;                end
            2'd1:    begin size_strb = STRB_W'(8'h03); lane_mask = ~LANE_W'(1);       end
            2'd2:    begin size_strb = STRB_W'(8'h0f); lane_mask = ~LANE_W'(3);       end
            default: begin size_strb = STRB_W'(8'hff); lane_mask = ~LANE_W'(7);       end
        endcase
    end
    // Dropping the sub-size lane bits makes a misaligned access behave as the aligned one.
    assign lane_eff = lane_raw & lane_mask;

    assign ip       = {cp0_cause[15] | cp0_cause[30], cp0_cause[14:8]};
    assign im       = cp0_status[15:8];
    assign int_pend = (in_exc == '0) && !cp0_status[1] && cp0_status[0] && (|(ip & im));

`ifdef MEM_MISALIGN_CHK_EN
    logic misalign;
    assign misalign = |(lane_raw & ~lane_mask);
    always_comb begin
        exc_fin = in_exc;
        if (int_pend)
            exc_fin = EXC_INT;
        else if (in_exc == '0 && misalign && in_load)
            exc_fin = EXC_ADEL;
        else if (in_exc == '0 && misalign && in_store)
            exc_fin = EXC_ADES;
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{EXC_ADEL, EXC_ADES};
    assign exc_fin    = int_pend ? EXC_INT : in_exc;
`endif

    assign in_ready = ready_en_q && (state_q == S_IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign access   = (in_load || in_store) && (exc_fin == '0);

    assign rsh = drsp_rdata >> {p_lane_q, 3'b000};
    always_comb begin
        keep = '1;
        sbit = 1'b0;
        case (p_size_q)
            2'd0:    begin keep = DATA_W'(64'hff);        sbit = rsh[7];  end
            2'd1:    begin keep = DATA_W'(64'hffff);      sbit = rsh[15]; end
            2'd2:    begin keep = DATA_W'(64'hffff_ffff); sbit = rsh[31]; end
            default: begin keep = '1;                     sbit = 1'b0;    end
        endcase
        ld_data = (rsh & keep) | ((p_signed_q && sbit) ? ~keep : '0);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept && access) state_d = S_REQ;
            S_REQ:   if (dreq_ready)       state_d = S_WAIT;
            S_WAIT:  if (drsp_valid)       state_d = S_IDLE;
            default:                       state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            ready_en_q     <= 1'b0;
            dreq_valid_q   <= 1'b0;
            dreq_we_q      <= 1'b0;
            dreq_addr_q    <= '0;
            dreq_wstrb_q   <= '0;
            dreq_wdata_q   <= '0;
            p_pc_q         <= '0;
            p_rf_we_q      <= 1'b0;
            p_load_q       <= 1'b0;
            p_signed_q     <= 1'b0;
            p_waddr_q      <= '0;
            p_lane_q       <= '0;
            p_size_q       <= '0;
            p_result_q     <= '0;
            out_valid_q    <= 1'b0;
            out_pc_q       <= '0;
            out_rf_we_q    <= 1'b0;
            out_rf_waddr_q <= '0;
            out_rf_wdata_q <= '0;
            out_exc_q      <= '0;
            flush_q        <= 1'b0;
            new_pc_q       <= '0;
        end else begin
            state_q    <= state_d;
            ready_en_q <= 1'b1;
            flush_q    <= 1'b0;
            if (out_valid_q && out_ready)
                out_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: if (accept) begin
                    if (access) begin
                        dreq_valid_q <= 1'b1;
                        dreq_we_q    <= in_store && !in_load;
                        dreq_addr_q  <= {in_addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
                        dreq_wstrb_q <= size_strb << lane_eff;
                        dreq_wdata_q <= in_wdata << {lane_eff, 3'b000};
                        p_pc_q       <= in_pc;
                        p_rf_we_q    <= in_rf_we;
                        p_load_q     <= in_load;
                        p_signed_q   <= in_signed;
                        p_waddr_q    <= in_rf_waddr;
                        p_lane_q     <= lane_eff;
                        p_size_q     <= size_eff;
                        p_result_q   <= in_result;
                    end else begin
                        out_valid_q    <= 1'b1;
                        out_pc_q       <= in_pc;
                        out_rf_we_q    <= in_rf_we && (exc_fin == '0);
                        out_rf_waddr_q <= in_rf_waddr;
                        out_rf_wdata_q <= in_result;
                        out_exc_q      <= exc_fin;
                        if (exc_fin != '0) begin
                            flush_q  <= 1'b1;
                            new_pc_q <= (exc_fin == EXC_ERET) ? cp0_epc : EXC_VECTOR;
                        end
                    end
                end
                S_REQ: if (dreq_ready)
                    dreq_valid_q <= 1'b0;
                S_WAIT: if (drsp_valid) begin
                    out_valid_q    <= 1'b1;
                    out_pc_q       <= p_pc_q;
                    out_rf_we_q    <= p_rf_we_q;
                    out_rf_waddr_q <= p_waddr_q;
                    out_rf_wdata_q <= p_load_q ? ld_data : p_result_q;
                    out_exc_q      <= '0;
                end
                default: ;
            endcase
        end
    end

    logic unused_cp0;
    assign unused_cp0 = ^{cp0_status[31:16], cp0_status[7:2], cp0_cause[31], cp0_cause[29:16], cp0_cause[7:0]};

    assign dreq_valid   = dreq_valid_q;
    assign dreq_we      = dreq_we_q;
    assign dreq_addr    = dreq_addr_q;
    assign dreq_wstrb   = dreq_wstrb_q;
    assign dreq_wdata   = dreq_wdata_q;
    assign out_valid    = out_valid_q;
    assign out_pc       = out_pc_q;
    assign out_rf_we    = out_rf_we_q;
    assign out_rf_waddr = out_rf_waddr_q;
    assign out_rf_wdata = out_rf_wdata_q;
    assign out_exc      = out_exc_q;
    assign flush        = flush_q;
    assign new_pc       = new_pc_q;
    assign stall_req    = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (DATA_W=32): lane alignment, interrupts/ERET, backpressure, reset mid-access.
module tb_mem_access_unit;
    localparam logic [4:0]  X_INT  = 5'h10;
    localparam logic [4:0]  X_ERET = 5'h0e;
    localparam logic [4:0]  X_ADEL = 5'h04;
    localparam logic [4:0]  X_ADES = 5'h05;
    localparam logic [31:0] VEC    = 32'hbfc0_0380;

    logic        clk, rst_n;
    logic        in_valid, in_ready;
    logic [31:0] in_pc, in_addr, in_wdata, in_result;
    logic [1:0]  in_size;
    logic        in_load, in_store, in_signed, in_rf_we;
    logic [4:0]  in_rf_waddr, in_exc;
    logic [31:0] cp0_status, cp0_cause, cp0_epc;
    logic        dreq_valid, dreq_ready, dreq_we;
    logic [31:0] dreq_addr, dreq_wdata;
    logic [3:0]  dreq_wstrb;
    logic        drsp_valid;
    logic [31:0] drsp_rdata;
    logic        out_valid, out_ready, out_rf_we, flush, stall_req;
    logic [31:0] out_pc, out_rf_wdata, new_pc;
    logic [4:0]  out_rf_waddr, out_exc;

    mem_access_unit #(
        .DATA_W(32), .ADDR_W(32), .EXC_W(5), .EXC_VECTOR(VEC),
        .EXC_INT(X_INT), .EXC_ERET(X_ERET), .EXC_ADEL(X_ADEL), .EXC_ADES(X_ADES)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_addr(in_addr),
        .in_wdata(in_wdata), .in_size(in_size), .in_load(in_load), .in_store(in_store),
        .in_signed(in_signed), .in_rf_we(in_rf_we), .in_rf_waddr(in_rf_waddr),
        .in_result(in_result), .in_exc(in_exc),
        .cp0_status(cp0_status), .cp0_cause(cp0_cause), .cp0_epc(cp0_epc),
        .dreq_valid(dreq_valid), .dreq_ready(dreq_ready), .dreq_we(dreq_we),
        .dreq_addr(dreq_addr), .dreq_wstrb(dreq_wstrb), .dreq_wdata(dreq_wdata),
        .drsp_valid(drsp_valid), .drsp_rdata(drsp_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rf_we(out_rf_we), .out_rf_waddr(out_rf_waddr), .out_rf_wdata(out_rf_wdata),
        .out_exc(out_exc), .flush(flush), .new_pc(new_pc), .stall_req(stall_req)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Bus responder: raises dreq_ready after rdy_dly sampled cycles of dreq_valid, then drsp_valid rsp_dly cycles later.
    int          rdy_dly = 1, rsp_dly = 1, req_cnt = 0, req_age = 0, rsp_age = 0;
    bit          in_wait = 0;
    logic [31:0] rsp_data = '0, cap_addr = '0, cap_wdata = '0;
    logic [3:0]  cap_wstrb = '0;
    logic        cap_we = 1'b0;

    initial begin
        dreq_ready = 1'b0;
        drsp_valid = 1'b0;
        drsp_rdata = '0;
        forever begin
            @(negedge clk);
            dreq_ready = 1'b0;
            drsp_valid = 1'b0;
            if (!rst_n) begin
                in_wait = 0; req_age = 0; rsp_age = 0;
            end else if (dreq_valid) begin
                req_age++;
                if (req_age >= rdy_dly) begin
                    dreq_ready = 1'b1;
                    req_age = 0; rsp_age = 0; in_wait = 1; req_cnt++;
                    cap_addr = dreq_addr; cap_wdata = dreq_wdata; cap_wstrb = dreq_wstrb; cap_we = dreq_we;
                end
            end else if (in_wait) begin
                rsp_age++;
                if (rsp_age >= rsp_dly) begin
                    drsp_valid = 1'b1;
                    drsp_rdata = rsp_data;
                    in_wait = 0;
                end
            end
        end
    end

    task automatic clear_in();
        in_valid = 1'b0; in_pc = '0; in_addr = '0; in_wdata = '0; in_result = '0;
        in_size = '0; in_load = 1'b0; in_store = 1'b0; in_signed = 1'b0;
        in_rf_we = 1'b0; in_rf_waddr = '0; in_exc = '0;
        cp0_status = '0; cp0_cause = '0; cp0_epc = '0;
    endtask

    // Called just after a negedge with fields set; returns at the negedge following the accepting edge.
    task automatic send();
        int n = 0;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("accept_timeout", 64'd0, 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic get_out(output int lat, output int stalls);
        lat = 0;
        stalls = 0;
        while (!out_valid && lat < 60) begin
            stalls += int'(stall_req);
            @(negedge clk);
            lat++;
        end
        stalls += int'(stall_req);
        if (!out_valid) chk("out_timeout", 64'd0, 64'd1);
    endtask

    int lat, stalls, rc, seen;
    logic [31:0] hold_pc;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_in();
        out_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_dreq_valid", dreq_valid, 0);
        chk("rst_flush", flush, 0);
        chk("rst_stall", stall_req, 0);
        chk("rst_in_ready", in_ready, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // lb from lane 3, sign-extended, 2-cycle ready and 2-cycle response
        clear_in();
        in_load = 1; in_signed = 1; in_size = 2'd0; in_addr = 32'h1000_0003;
        in_rf_we = 1; in_rf_waddr = 5'd7; in_pc = 32'h0000_0400;
        rdy_dly = 2; rsp_dly = 2; rsp_data = 32'h8012_3456;
        send(); get_out(lat, stalls);
        chk("lb_data", out_rf_wdata, 32'hffff_ff80);
        chk("lb_we", out_rf_we, 1);
        chk("lb_waddr", out_rf_waddr, 7);
        chk("lb_pc", out_pc, 32'h0000_0400);
        chk("lb_exc", out_exc, 0);
        chk("lb_flush", flush, 0);
        chk("lb_lat", lat, 4);
        chk("lb_stall", stalls, 4);
        chk("lb_addr", cap_addr, 32'h1000_0000);
        chk("lb_we_bus", cap_we, 0);
        @(negedge clk);
        chk("lb_drain", out_valid, 0);

        // lbu, lhu, lh on the same style of responses
        rdy_dly = 1; rsp_dly = 1;
        in_signed = 0;
        send(); get_out(lat, stalls);
        chk("lbu_data", out_rf_wdata, 32'h0000_0080);
        @(negedge clk);
        in_size = 2'd1; in_addr = 32'h1000_0002; rsp_data = 32'h8001_0000;
        send(); get_out(lat, stalls);
        chk("lhu_data", out_rf_wdata, 32'h0000_8001);
        @(negedge clk);
        in_signed = 1;
        send(); get_out(lat, stalls);
        chk("lh_data", out_rf_wdata, 32'hffff_8001);
        @(negedge clk);

        // sh to upper half
        clear_in();
        in_store = 1; in_size = 2'd1; in_addr = 32'h2000_0006; in_wdata = 32'h0000_1234;
        rc = req_cnt;
        send(); get_out(lat, stalls);
        chk("sh_req", req_cnt - rc, 1);
        chk("sh_wstrb", cap_wstrb, 4'b1100);
        chk("sh_wdata", cap_wdata, 32'h1234_0000);
        chk("sh_addr", cap_addr, 32'h2000_0004);
        chk("sh_we_bus", cap_we, 1);
        chk("sh_exc", out_exc, 0);
        @(negedge clk);

        // pending interrupt on an ALU op
        clear_in();
        cp0_status = 32'h0000_8001; cp0_cause = 32'h4000_0000;
        in_rf_we = 1; in_result = 32'h55; in_pc = 32'h0000_0500;
        rc = req_cnt;
        send(); get_out(lat, stalls);
        chk("int_lat", lat, 0);
        chk("int_exc", out_exc, X_INT);
        chk("int_we", out_rf_we, 0);
        chk("int_flush", flush, 1);
        chk("int_newpc", new_pc, VEC);
        @(negedge clk);
        chk("int_flush_drop", flush, 0);
        chk("int_noreq", req_cnt - rc, 0);

        // EXL set masks the interrupt
        cp0_status = 32'h0000_8003;
        send(); get_out(lat, stalls);
        chk("exl_exc", out_exc, 0);
        chk("exl_we", out_rf_we, 1);
        chk("exl_data", out_rf_wdata, 32'h55);
        chk("exl_flush", flush, 0);
        @(negedge clk);

        // ERET redirect to EPC
        clear_in();
        in_exc = X_ERET; cp0_epc = 32'h8000_0100; in_rf_we = 1;
        send(); get_out(lat, stalls);
        chk("eret_flush", flush, 1);
        chk("eret_newpc", new_pc, 32'h8000_0100);
        chk("eret_exc", out_exc, X_ERET);
        chk("eret_we", out_rf_we, 0);
        @(negedge clk);
        chk("eret_flush_drop", flush, 0);

        // WB backpressure holds the output register
        clear_in();
        out_ready = 1'b0;
        in_rf_we = 1; in_result = 32'h0000_a5a5; in_pc = 32'h0000_0600;
        send(); get_out(lat, stalls);
        hold_pc = 32'h0000_0600;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", out_valid, 1);
            chk("bp_data", out_rf_wdata, 32'h0000_a5a5);
            chk("bp_pc", out_pc, hold_pc);
            chk("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", out_valid, 0);
        chk("bp_ready_back", in_ready, 1);

        // reset while waiting for the load response
        clear_in();
        in_load = 1; in_size = 2'd2; in_addr = 32'h3000_0000; in_rf_we = 1;
        rdy_dly = 1; rsp_dly = 20; rsp_data = 32'h1111_2222;
        send();
        for (int i = 0; i < 20 && !(in_wait && !dreq_valid); i++) @(negedge clk);
        chk("rw_in_wait", stall_req, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rw_stall", stall_req, 0);
        chk("rw_dreq", dreq_valid, 0);
        chk("rw_out", {out_valid, out_rf_we, flush, in_ready}, 0);
        chk("rw_data", out_rf_wdata, 0);
        chk("rw_pc", {out_pc, new_pc}, 0);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            seen += int'(out_valid);
        end
        chk("rw_dropped", seen, 0);

        // lw at a half-word offset
        clear_in();
        in_load = 1; in_size = 2'd2; in_addr = 32'h3000_0002; in_rf_we = 1;
        rdy_dly = 1; rsp_dly = 1; rsp_data = 32'hdead_beef;
        rc = req_cnt;
        send(); get_out(lat, stalls);
`ifdef MEM_MISALIGN_CHK_EN
        chk("mis_exc", out_exc, X_ADEL);
        chk("mis_flush", flush, 1);
        chk("mis_newpc", new_pc, VEC);
        chk("mis_we", out_rf_we, 0);
        chk("mis_noreq", req_cnt - rc, 0);
`else
        chk("mis_exc", out_exc, 0);
        chk("mis_req", req_cnt - rc, 1);
        chk("mis_addr", cap_addr, 32'h3000_0000);
        chk("mis_data", out_rf_wdata, 32'hdead_beef);
        chk("mis_flush", flush, 0);
`endif
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
